// File: rtl/boot_copier.sv
`timescale 1ns/1ps
// boot_copier: copies the boot ROM into main RAM and holds the CPU until the copy finishes.
module boot_copier #(
    parameter int                ROM_WORDS    = 16,
    parameter int                RAM_AW       = 12,
    parameter logic [RAM_AW-1:0] RAM_BASE     = '0,
    parameter bit                STOP_ON_ZERO = 1'b1,
    parameter bit                AUTOSTART    = 1'b1
) (
    input  logic              romclk,
    input  logic              rst,
    input  logic              start,
    output logic              rom_cs,
    output logic              rom_we,
    output logic [3:0]        rom_addr,
    input  logic [15:0]       rom_dout,
    output logic              ram_req,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [15:0]       ram_wdata,
    input  logic              ram_gnt,
    output logic              busy,
    output logic              done,
    output logic              cpu_hold,
    output logic [4:0]        word_count,
    output logic [15:0]       checksum
);
    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WRITE, DONE} state_t;
    localparam logic [4:0] LAST = 5'(ROM_WORDS - 1);
    state_t      r_state, w_state_n;
    logic [4:0]  r_idx, w_idx_n, w_count_n;
    logic [15:0] r_data, w_data_n, w_sum_n;
    always_comb begin
        w_state_n = r_state;
        w_idx_n   = r_idx;
        w_data_n  = r_data;
        w_count_n = word_count;
        w_sum_n   = checksum;
        case (r_state)
            IDLE, DONE: begin
                if ((r_state == IDLE && AUTOSTART) || start) begin
                    w_state_n = RADDR;
                    w_idx_n   = '0;
                    w_count_n = '0;
                    w_sum_n   = '0;
                end
            end
            RADDR: w_state_n = RDATA;
            RDATA: begin
                w_data_n  = rom_dout;
                w_state_n = (STOP_ON_ZERO && rom_dout == 16'h0000) ? DONE : WRITE;
            end
            WRITE: begin
                if (ram_gnt) begin
                    w_sum_n   = checksum + r_data;
                    w_count_n = word_count + 5'd1;
                    w_state_n = (r_idx == LAST) ? DONE : RADDR;
                    w_idx_n   = (r_idx == LAST) ? r_idx : r_idx + 5'd1;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end
    // every output is decoded from the next state so it is a plain flop
    always_ff @(posedge romclk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_data     <= '0;
            word_count <= '0;
            checksum   <= '0;
            rom_cs     <= 1'b0;
            rom_we     <= 1'b0;
            rom_addr   <= '0;
            ram_req    <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cpu_hold   <= 1'b1;
        end else begin
            r_state    <= w_state_n;
            r_idx      <= w_idx_n;
            r_data     <= w_data_n;
            word_count <= w_count_n;
            checksum   <= w_sum_n;
            rom_cs     <= (w_state_n == RADDR) || (w_state_n == RDATA);
            rom_we     <= 1'b0;
            rom_addr   <= w_idx_n[3:0];
            ram_req    <= w_state_n == WRITE;
            ram_addr   <= RAM_BASE + RAM_AW'(w_idx_n);
            ram_wdata  <= w_data_n;
            busy       <= (w_state_n == RADDR) || (w_state_n == RDATA) || (w_state_n == WRITE);
            done       <= w_state_n == DONE;
            cpu_hold   <= w_state_n != DONE;
        end
    end
endmodule

// File: tb/tb_boot_copier.sv
`timescale 1ns/1ps
// tb_boot_copier: four boot_copier instances (stock, no-stop, manual start, high RAM base) checked against a ROM/RAM model.
module tb_boot_copier;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [3:0]  SOZ   = 4'b1101;
    localparam logic [3:0]  AS    = 4'b1011;
    localparam logic [47:0] BASES = {12'hFFE, 12'h000, 12'h000, 12'h000};
    localparam logic [15:0] STOCK [8] = '{16'hF200, 16'h4000, 16'hF800, 16'h1007,
                                          16'hF400, 16'h3008, 16'h4000, 16'h0000};
    localparam logic [58:0] RST_V = {1'b0, 1'b0, 4'h0, 1'b0, 12'h000, 16'h0000,
                                     1'b0, 1'b0, 1'b1, 5'd0, 16'h0000};

    logic        rst_v[4], start_v[4], gnt_v[4], clr[4];
    logic        cs_v[4], we_v[4], req_v[4], busy_v[4], done_v[4], hold_v[4];
    logic [3:0]  ra_v[4];
    logic [15:0] dout_v[4], wdat_v[4], cs16_v[4];
    logic [11:0] wa_v[4];
    logic [4:0]  wc_v[4];

    generate
        for (genvar g = 0; g < 4; g++) begin : g_dut
            boot_copier #(
                .ROM_WORDS(16), .RAM_AW(12), .RAM_BASE(BASES[g*12 +: 12]),
                .STOP_ON_ZERO(SOZ[g]), .AUTOSTART(AS[g])
            ) u_dut (
                .romclk(clk), .rst(rst_v[g]), .start(start_v[g]),
                .rom_cs(cs_v[g]), .rom_we(we_v[g]), .rom_addr(ra_v[g]), .rom_dout(dout_v[g]),
                .ram_req(req_v[g]), .ram_addr(wa_v[g]), .ram_wdata(wdat_v[g]), .ram_gnt(gnt_v[g]),
                .busy(busy_v[g]), .done(done_v[g]), .cpu_hold(hold_v[g]),
                .word_count(wc_v[g]), .checksum(cs16_v[g])
            );
        end
    endgenerate

    logic [15:0] rom[4][16];
    always @(posedge clk)
        for (int g = 0; g < 4; g++)
            if (cs_v[g]) dout_v[g] <= rom[g][ra_v[g]];

    // write log per instance, plus a count of requests that changed while stalled
    int          nw[4], bad[4];
    logic        pend[4];
    logic [11:0] pa[4];
    logic [15:0] pd[4];
    logic [11:0] la[4][32];
    logic [15:0] ld[4][32];
    always @(posedge clk)
        for (int g = 0; g < 4; g++) begin
            if (clr[g]) begin
                nw[g] <= 0; bad[g] <= 0; pend[g] <= 1'b0;
            end else if (rst_v[g]) begin
                pend[g] <= 1'b0;
            end else begin
                if (req_v[g] && gnt_v[g]) begin
                    if (nw[g] < 32) begin
                        la[g][nw[g]] <= wa_v[g];
                        ld[g][nw[g]] <= wdat_v[g];
                    end
                    nw[g] <= nw[g] + 1;
                end
                if ((pend[g] && !(req_v[g] && wa_v[g] == pa[g] && wdat_v[g] == pd[g])) || we_v[g])
                    bad[g] <= bad[g] + 1;
                pend[g] <= req_v[g] && !gnt_v[g];
                pa[g]   <= wa_v[g];
                pd[g]   <= wdat_v[g];
            end
        end

    // grant: instance 0 can stall each request 0..3 cycles and toggles gnt randomly while idle
    logic stall_en = 1'b0;
    int   sl = -1;
    always @(negedge clk) begin
        for (int g = 1; g < 4; g++) gnt_v[g] = 1'b1;
        if (!stall_en) begin
            gnt_v[0] = 1'b1; sl = -1;
        end else if (!req_v[0]) begin
            gnt_v[0] = 1'($urandom_range(0, 1)); sl = -1;
        end else begin
            if (sl < 0) sl = int'($urandom_range(0, 3));
            gnt_v[0] = (sl == 0);
            sl = sl - 1;
        end
    end

    typedef struct {int g; int nw; int sum; int edges;} run_t;
    run_t runs[8];
    int   tests = 0, fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [58:0] outv(input int g);
        return {cs_v[g], we_v[g], ra_v[g], req_v[g], wa_v[g], wdat_v[g],
                busy_v[g], done_v[g], hold_v[g], wc_v[g], cs16_v[g]};
    endfunction

    task automatic wait_done(input int g, output int n);
        n = 0;
        while (!done_v[g] && n < 200) begin
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic wait_write(input int g, input logic [11:0] a, output int n);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!(req_v[g] && wa_v[g] == a) && n < 200);
    endtask

    task automatic check_run(input int r, input int edges);
        int g;
        logic [11:0] ea;
        g = runs[r].g;
        if (runs[r].edges >= 0)
            chk($sformatf("run%0d edges", r), 64'(edges), 64'(runs[r].edges));
        chk($sformatf("run%0d writes", r), 64'(nw[g]), 64'(runs[r].nw));
        chk($sformatf("run%0d word_count", r), 64'(wc_v[g]), 64'(runs[r].nw));
        chk($sformatf("run%0d checksum", r), 64'(cs16_v[g]), 64'(runs[r].sum));
        chk($sformatf("run%0d done/busy/hold", r), 64'({done_v[g], busy_v[g], hold_v[g]}), 64'(3'b100));
        chk($sformatf("run%0d stall/we errors", r), 64'(bad[g]), 64'(0));
        for (int k = 0; k < runs[r].nw && k < nw[g] && k < 32; k++) begin
            ea = BASES[g*12 +: 12] + 12'(k);
            chk($sformatf("run%0d addr%0d", r, k), 64'(la[g][k]), 64'(ea));
            chk($sformatf("run%0d data%0d", r, k), 64'(ld[g][k]), 64'(rom[g][k]));
        end
    endtask

    initial begin
        int first[4];
        int n, m;
        runs[0] = '{0,  7, 'h9E0F, 24};
        runs[1] = '{1, 16, 'hB043, 49};
        runs[2] = '{3,  7, 'h9E0F, 24};
        runs[3] = '{0,  7, 'h9E0F, 24};
        runs[4] = '{0,  7, 'h9E0F, -1};
        runs[5] = '{2,  7, 'h9E0F, 24};
        runs[6] = '{1, 16, 'hB043, 49};
        runs[7] = '{2,  7, 'h9E0F, 24};
        for (int g = 0; g < 4; g++) begin
            for (int k = 0; k < 16; k++) rom[g][k] = (k < 8) ? STOCK[k] : 16'h0000;
            rst_v[g] = 1'b1; start_v[g] = 1'b0; clr[g] = 1'b1; first[g] = 0;
        end
        rom[1][15] = 16'h1234;
        repeat (2) @(negedge clk);
        for (int g = 0; g < 4; g++) chk($sformatf("reset outputs inst%0d", g), 64'(outv(g)), 64'(RST_V));
        for (int g = 0; g < 4; g++) begin clr[g] = 1'b0; rst_v[g] = 1'b0; end
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk); #1;
            for (int g = 0; g < 4; g++) if (done_v[g] && first[g] == 0) first[g] = e;
        end
        chk("manual-start idle cs/hold/busy/done", 64'({cs_v[2], hold_v[2], busy_v[2], done_v[2]}), 64'(4'b0100));
        check_run(0, first[0]);
        check_run(1, first[1]);
        check_run(2, first[3]);

        // reset in the middle of the write of word 3, then autostart again
        @(negedge clk); rst_v[0] = 1'b1; clr[0] = 1'b1;
        @(negedge clk); clr[0] = 1'b0; rst_v[0] = 1'b0;
        wait_write(0, 12'd3, n);
        chk("word3 write reached", 64'(req_v[0]), 64'(1));
        rst_v[0] = 1'b1; #1;
        chk("async reset mid-copy", 64'(outv(0)), 64'(RST_V));
        clr[0] = 1'b1;
        @(negedge clk); @(negedge clk); clr[0] = 1'b0; rst_v[0] = 1'b0;
        wait_done(0, n);
        check_run(3, n);

        // random grant stalls
        @(negedge clk); rst_v[0] = 1'b1; clr[0] = 1'b1; stall_en = 1'b1;
        @(negedge clk); clr[0] = 1'b0; rst_v[0] = 1'b0;
        wait_done(0, n);
        check_run(4, n);
        stall_en = 1'b0;

        // manual start, with a start pulse while busy
        @(negedge clk); start_v[2] = 1'b1;
        @(posedge clk); #1; start_v[2] = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        chk("busy during copy", 64'(busy_v[2]), 64'(1));
        start_v[2] = 1'b1;
        @(posedge clk); #1; start_v[2] = 1'b0;
        wait_done(2, m);
        check_run(5, 10 + m);

        // restart from DONE; start coincides with the final grant
        @(negedge clk); clr[1] = 1'b1;
        @(negedge clk); clr[1] = 1'b0; start_v[1] = 1'b1;
        @(posedge clk); #1; start_v[1] = 1'b0;
        chk("restart done/hold/busy", 64'({done_v[1], hold_v[1], busy_v[1]}), 64'(3'b011));
        chk("restart counters cleared", 64'({wc_v[1], cs16_v[1]}), 64'(0));
        wait_write(1, 12'd15, n);
        start_v[1] = 1'b1;
        @(posedge clk); #1; start_v[1] = 1'b0;
        chk("start with last grant", 64'({done_v[1], busy_v[1]}), 64'(2'b10));
        n = n + 2;
        repeat (3) begin @(posedge clk); #1; end
        check_run(6, n);

        // second copy on the manual-start instance
        @(negedge clk); clr[2] = 1'b1;
        @(negedge clk); clr[2] = 1'b0; start_v[2] = 1'b1;
        @(posedge clk); #1; start_v[2] = 1'b0;
        wait_done(2, m);
        check_run(7, 1 + m);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
